clk_divider_bank: RTL and testbench

Multi-channel, runtime-programmable clock divider for the lab's clock-generation layer. It produces NUM_CH independent divided clock-enable waveforms and matching rising-edge tick pulses from one system clock. Each channel's half-period is loaded through a simple write port and changes glitch-free at the channel's next toggle. A global resync restarts all channels phase-aligned. Downstream logic uses tick as a clock enable; clk_out is for observation and I/O pins.

---
 rtl/clk_divider_bank.sv | 113 +++++++++++
 tb/tb_clk_divider_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_bank.sv
`default_nettype none
// ============================================================================
//  Module   : clk_divider_bank
//  Purpose  : NUM_CH independent runtime-programmable clock dividers. Each
//             channel emits a registered divided clock (clk_out) and a
//             one-cycle rising-edge pulse (tick). Half-limits are written
//             into a shadow register and adopted only at the next toggle,
//             so a period is never truncated or stretched mid-flight.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_divider_bank #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         en,
  input  logic                      cfg_wr,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]          cfg_half,
  output logic                      cfg_ack,
  input  logic                      resync,
  output logic [NUM_CH-1:0]         clk_out,
  output logic [NUM_CH-1:0]         tick
);

  localparam int               CH_W     = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);

  // True when cfg_ch addresses an existing channel. With a power-of-two
  // channel count every encoding is valid, so no compare is needed.
  logic ch_ok;

  generate
    if (NUM_CH == (1 << CH_W)) begin : g_ch_full
      assign ch_ok = 1'b1;
    end else begin : g_ch_part
      assign ch_ok = (32'(cfg_ch) < NUM_CH);
    end
  endgenerate

  // Write acknowledge: one cycle after an accepted write.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_ack <= 1'b0;
    end else begin
      cfg_ack <= cfg_wr & ch_ok;
    end
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] act;
      logic [CNT_W-1:0] shd;
      logic [CNT_W-1:0] shd_nxt;
      logic             out_r;
      logic             tick_r;
      logic             wr_hit;
      logic             run;
      logic             at_lim;

      // A same-cycle write is folded into the shadow value before any
      // toggle or resync copies it into the active limit.
      assign wr_hit  = cfg_wr & ch_ok & (cfg_ch == CH_W'(i));
      assign shd_nxt = wr_hit ? cfg_half : shd;

      // A disabled channel that is currently high keeps counting so the
      // high half completes; it then parks low.
      assign run    = en[i] | out_r;
      assign at_lim = (cnt == act);

      // Per-channel divider: resync clears, otherwise count up to the
      // active limit and toggle, adopting the shadow limit at each toggle.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt    <= '0;
          act    <= RST_HALF;
          shd    <= RST_HALF;
          out_r  <= 1'b0;
          tick_r <= 1'b0;
        end else begin
          shd <= shd_nxt;
          if (resync) begin
            cnt    <= '0;
            act    <= shd_nxt;
            out_r  <= 1'b0;
            tick_r <= 1'b0;
          end else if (run) begin
            if (at_lim) begin
              cnt    <= '0;
              act    <= shd_nxt;
              out_r  <= ~out_r;
              tick_r <= ~out_r;
            end else begin
              cnt    <= cnt + CNT_W'(1);
              tick_r <= 1'b0;
            end
          end else begin
            cnt    <= '0;
            tick_r <= 1'b0;
          end
        end
      end

      assign clk_out[i] = out_r;
      assign tick[i]    = tick_r;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_divider_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_divider_bank
//  Purpose  : Self-checking bench for clk_divider_bank. A countdown-based
//             reference model predicts clk_out/tick/cfg_ack every cycle;
//             directed sequences measure edge counts against fixed values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clk_divider_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int DEF    = 1000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] en = '0;
  logic              cfg_wr = 1'b0;
  logic [1:0]        cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_half = '0;
  logic              resync = 1'b0;
  logic              cfg_ack;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  // Small 3-channel instance: exercises an unused cfg_ch encoding.
  logic       reset3 = 1'b1;
  logic [2:0] en3 = '0;
  logic       cfg_wr3 = 1'b0;
  logic [1:0] cfg_ch3 = '0;
  logic [3:0] cfg_half3 = '0;
  logic       resync3 = 1'b0;
  logic       cfg_ack3;
  logic [2:0] clk_out3;
  logic [2:0] tick3;

  always #5 clk = ~clk;

  clk_divider_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_HALF(DEF)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_half(cfg_half), .cfg_ack(cfg_ack), .resync(resync),
    .clk_out(clk_out), .tick(tick)
  );

  clk_divider_bank #(.NUM_CH(3), .CNT_W(4), .DEFAULT_HALF(2)) dut3 (
    .clk(clk), .reset(reset3), .en(en3), .cfg_wr(cfg_wr3), .cfg_ch(cfg_ch3),
    .cfg_half(cfg_half3), .cfg_ack(cfg_ack3), .resync(resync3),
    .clk_out(clk_out3), .tick(tick3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: each channel tracks edges remaining until its next
  // toggle, the half-limit governing the current half, and the pending one.
  int                rem  [NUM_CH];
  int                cur  [NUM_CH];
  int                pend [NUM_CH];
  bit [NUM_CH-1:0]   m_lvl;
  bit [NUM_CH-1:0]   m_tick;
  bit                m_ack;

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        rem[i] = DEF + 1; cur[i] = DEF; pend[i] = DEF;
      end
      m_lvl = '0; m_tick = '0; m_ack = 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        int nl;
        nl = (cfg_wr && int'(cfg_ch) == i) ? int'(cfg_half) : pend[i];
        m_tick[i] = 1'b0;
        if (resync) begin
          m_lvl[i] = 1'b0; cur[i] = nl; rem[i] = nl + 1;
        end else if (en[i] || m_lvl[i]) begin
          rem[i] = rem[i] - 1;
          if (rem[i] == 0) begin
            m_lvl[i]  = ~m_lvl[i];
            m_tick[i] = m_lvl[i];
            cur[i]    = nl;
            rem[i]    = nl + 1;
          end
        end else begin
          rem[i] = cur[i] + 1;
        end
        pend[i] = nl;
      end
      m_ack = cfg_wr;
    end
  endtask

  // One clock: advance the model with the inputs the DUT samples, then
  // compare all main-instance outputs just after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("outputs", {23'd0, cfg_ack, tick, clk_out}, {23'd0, m_ack, m_tick, m_lvl});
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Edges until clk_out[ch] reaches val, bounded; bound overrun shows up
  // as a mismatched count at the caller's check.
  task automatic wait_bit(input int ch, input bit val, input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (clk_out[ch] !== val && n < bound);
  endtask

  task automatic write_cfg(input int ch, input int half);
    cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_half = CNT_W'(half);
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  initial begin
    int n;

    // Out-of-range channel on a 3-channel bank, main bank held in reset.
    reset = 1'b1;
    reset3 = 1'b1; step();
    check("reset_outs", {23'd0, cfg_ack, tick, clk_out}, 32'd0);
    reset3 = 1'b0; en3 = 3'b111;
    cfg_wr3 = 1'b1; cfg_ch3 = 2'd3; cfg_half3 = 4'd0;
    step();
    cfg_wr3 = 1'b0;
    check("oor_no_ack", {31'd0, cfg_ack3}, 32'd0);
    step();
    check("oor_low", {29'd0, clk_out3}, 32'd0);
    step();
    check("oor_rise3", {29'd0, clk_out3}, 32'd7);
    check("oor_tick3", {29'd0, tick3}, 32'd7);
    cfg_wr3 = 1'b1; cfg_ch3 = 2'd2; step(); cfg_wr3 = 1'b0;
    check("inrange_ack", {31'd0, cfg_ack3}, 32'd1);

    // Default limits: first rise 1001 edges after release, 1001 high.
    do_reset();
    en = 4'hF;
    wait_bit(0, 1'b1, 3000, n);
    check("first_rise", n, 1001);
    wait_bit(0, 1'b0, 3000, n);
    check("high_half", n, 1001);
    wait_bit(0, 1'b1, 3000, n);
    check("low_half", n, 1001);
    steps(5000 - 3003);

    // Reprogram ch1 mid-low-half; current half still completes.
    do_reset();
    steps(400);
    write_cfg(1, 2);
    check("ack_ch1", {31'd0, cfg_ack}, 32'd1);
    wait_bit(1, 1'b1, 3000, n);
    check("ch1_first_rise", n, 600);
    wait_bit(1, 1'b0, 100, n);
    check("ch1_high3", n, 3);
    wait_bit(1, 1'b1, 100, n);
    check("ch1_low3", n, 3);
    steps(30);

    // ch2 to clk/2 then resync; channels realign.
    write_cfg(2, 0);
    resync = 1'b1; step(); resync = 1'b0;
    wait_bit(2, 1'b1, 10, n);
    check("ch2_rise", n, 1);
    wait_bit(1, 1'b1, 10, n);
    check("ch1_rise_after_resync", n, 2);
    steps(40);

    // Drop en[0] 10 cycles into a high half.
    do_reset();
    wait_bit(0, 1'b1, 3000, n);
    steps(10);
    en[0] = 1'b0;
    wait_bit(0, 1'b0, 3000, n);
    check("en0_drain", n, 991);
    en[3] = 1'b0;
    steps(100);
    check("en_off_low", {30'd0, clk_out[3], clk_out[0]}, 32'd0);
    en = 4'hF;

    // Write merged with a same-cycle resync.
    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_half = 16'd3; resync = 1'b1;
    step();
    cfg_wr = 1'b0; resync = 1'b0;
    wait_bit(0, 1'b1, 3000, n);
    check("wr_resync_rise", n, 4);

    // Reset mid-period discards programmed limits.
    for (int c = 0; c < NUM_CH; c++) write_cfg(c, 5);
    resync = 1'b1; step(); resync = 1'b0;
    steps(8);
    reset = 1'b1; step();
    check("reset_mid", {23'd0, cfg_ack, tick, clk_out}, 32'd0);
    reset = 1'b0;
    wait_bit(3, 1'b1, 3000, n);
    check("post_reset_rise", n, 1001);
    wait_bit(3, 1'b0, 3000, n);
    check("post_reset_high", n, 1001);

    // Randomized traffic against the model.
    for (int k = 0; k < 15000; k++) begin
      cfg_wr   = ($urandom_range(0, 7) == 0);
      cfg_ch   = 2'($urandom_range(0, 3));
      cfg_half = CNT_W'($urandom_range(0, 9));
      resync   = ($urandom_range(0, 199) == 0);
      reset    = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 63) == 0) en[$urandom_range(0, 3)] ^= 1'b1;
      step();
    end
    cfg_wr = 1'b0; resync = 1'b0; reset = 1'b0;
    steps(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
